// File: rtl/modport_mem_pkg.sv
// Shared defaults and word/address types for the small synchronous register-file memory.
package modport_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;
  localparam logic [DEF_DATA_WIDTH-1:0] DEF_RESET_VALUE = 8'hFF;

  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/modport_mem_if.sv
// Single-port memory bus: one shared address, independent write and read enables.
interface modport_mem_if
  import modport_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output addr,
    output wr_en,
    output rd_en,
    output wdata,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wr_en,
    input  rd_en,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/modport_mem_array.sv
// Storage array with its write port; the word at addr is presented combinationally
// so the parent can register it on the same edge that may also overwrite it.
module modport_mem_array
  import modport_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DEF_RESET_VALUE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset wins over a coincident write, so a write issued during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VALUE;
      end
    end else if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  assign word = mem[addr];

endmodule

// File: rtl/modport_mem.sv
// Top of the memory: the array plus the registered read port and reset sequencing.
module modport_mem
  import modport_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DEF_RESET_VALUE
) (
  input  logic         clk,
  input  logic         reset,
  modport_mem_if.slave bus
);

  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] rdata_q;

  modport_mem_array #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .wr_en (bus.wr_en),
    .addr  (bus.addr),
    .wdata (bus.wdata),
    .word  (word)
  );

  // word still holds the pre-write value at this edge, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (bus.rd_en) begin
      rdata_q <= word;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_modport_mem.sv
// Bench for modport_mem: directed vector table, a reset-timing sequence, and random traffic
// compared against an array-based reference model.
module tb_modport_mem;
  import modport_mem_pkg::*;

  typedef struct {
    logic  rst;
    logic  we;
    logic  re;
    addr_t addr;
    word_t wdata;
    word_t exp;
  } vec_t;

  localparam int NUM_VECS = 24;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  word_t ref_mem [DEF_DEPTH];
  word_t ref_rdata;
  vec_t  vecs [NUM_VECS];

  modport_mem_if #(.ADDR_WIDTH(DEF_ADDR_WIDTH), .DATA_WIDTH(DEF_DATA_WIDTH)) bus ();

  modport_mem #(
    .ADDR_WIDTH  (DEF_ADDR_WIDTH),
    .DATA_WIDTH  (DEF_DATA_WIDTH),
    .RESET_VALUE (DEF_RESET_VALUE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drives one cycle, then advances the reference model by the same edge.
  task automatic apply_stimulus(input logic rst, input logic we, input logic re,
                                input addr_t a, input word_t d);
    reset     = rst;
    bus.wr_en = we;
    bus.rd_en = re;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    if (!rst) begin
      foreach (ref_mem[i]) ref_mem[i] = DEF_RESET_VALUE;
      ref_rdata = '0;
    end else begin
      if (re) ref_rdata = ref_mem[a];
      if (we) ref_mem[a] = d;
    end
  endtask

  task automatic check_output(input string name, input word_t exp);
    checks++;
    if (bus.rdata !== exp) begin
      failures++;
      $display("[TB] FAIL %s: rdata=%h expected=%h", name, bus.rdata, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    ref_rdata = '0;
    foreach (ref_mem[i]) ref_mem[i] = DEF_RESET_VALUE;

    //              rst   we    re    addr  wdata  expected rdata after the edge
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'hFF};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 8'hFF};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h00, 8'hFF};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 8'hFF};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 8'hA5, 8'hFF};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h00, 8'hA5};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h11, 8'hA5};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd1, 8'h22, 8'hA5};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd2, 8'h33, 8'hA5};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd3, 8'h44, 8'hA5};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 8'h44};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h00, 8'h33};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 8'h22};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'h11};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'h5A, 8'h22};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 8'h5A};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'h11};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 2'd1, 8'h99, 8'h11};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'h98, 8'h11};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 2'd3, 8'h97, 8'h11};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h77, 8'h00};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 8'hFF};

    for (int i = 0; i < NUM_VECS; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      check_output($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset asserted between edges must not disturb rdata until the next rising edge.
    apply_stimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'hC3);
    apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    check_output("seq_read_c3", 8'hC3);
    reset     = 1'b0;
    bus.rd_en = 1'b0;
    #2;
    check_output("seq_reset_no_async", 8'hC3);
    @(posedge clk);
    #1;
    foreach (ref_mem[i]) ref_mem[i] = DEF_RESET_VALUE;
    ref_rdata = '0;
    check_output("seq_reset_edge", 8'h00);
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'd0, 8'h3C);
    check_output("seq_first_op_old", 8'hFF);
    apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    check_output("seq_first_op_new", 8'h3C);

    for (int n = 0; n < 300; n++) begin
      apply_stimulus(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), addr_t'($urandom_range(0, DEF_DEPTH - 1)),
                     word_t'($urandom));
      check_output($sformatf("rand%0d", n), ref_rdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modport_mem.md
MODPORT_MEM -- requirements
Module: modport_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, SHALL be the address width; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL be the data word width.
REQ-003 Parameter RESET_VALUE, default 8'hFF, SHALL be the value loaded into every word on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: synchronous, active-low; sampled at rising clk edge.
REQ-006 addr  input  ADDR_WIDTH  SHALL be the word address for both write and read.
REQ-007 wr_en  input  1  SHALL be the write enable.
REQ-008 rd_en  input  1  SHALL be the read enable.
REQ-009 wdata  input  DATA_WIDTH  SHALL be the write data.
REQ-010 rdata  output  DATA_WIDTH  SHALL be the registered read data.

Function
REQ-011 Storage: DEPTH x DATA_WIDTH register array, no other architectural state except the rdata register.
REQ-012 Write: wr_en=1 at a rising edge (reset=1) SHALL store wdata into word addr at that edge.
REQ-013 Read: rd_en=1 at a rising edge (reset=1) SHALL load word addr into rdata at that edge; data visible one cycle after rd_en/addr are sampled.
REQ-014 rd_en=0: rdata SHALL hold its previous value.
REQ-015 wr_en=0: array SHALL not change.
REQ-016 wr_en=1 and rd_en=1 same edge, same address: rdata SHALL return the old (pre-write) word; array SHALL take wdata.
REQ-017 wr_en=1 and rd_en=1 same edge, different addresses: both operations SHALL complete independently in that cycle.
REQ-018 Addresses SHALL be fully decoded; no out-of-range case exists, no wrap logic required.
REQ-019 Back-to-back writes/reads every cycle SHALL be supported with no stall or handshake.
REQ-020 No combinational path from any input to rdata.

Reset
REQ-021 reset=0 at a rising edge SHALL set every array word to RESET_VALUE and rdata to 0.
REQ-022 Reset SHALL take priority over wr_en and rd_en in the same cycle; a write issued during reset SHALL be discarded.
REQ-023 Reset asserted mid-operation SHALL take effect at the next rising edge only; no asynchronous effect.
REQ-024 After reset deasserts, the first operation SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-025 Shared package modport_mem_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, DEPTH, RESET_VALUE defaults and the data-word and address typedefs.
REQ-026 One sub-module, modport_mem_array, SHALL hold the storage array and its write port; the top SHALL hold the read register and the reset sequencing.
REQ-027 The design SHALL be synthesizable with no latches and no initial blocks.

Verification
REQ-028 Reset held low 2 cycles, then rd_en at addr 0..3 -> rdata 8'hFF for each, one cycle after each read; rdata 8'h00 while in reset.
REQ-029 Write 8'hA5 to addr 2, next cycle read addr 2 -> rdata 8'hA5 one cycle after the read.
REQ-030 Write 8'h11,8'h22,8'h33,8'h44 to addr 0..3 back-to-back, then read 3,2,1,0 back-to-back -> 8'h44,8'h33,8'h22,8'h11 on consecutive cycles.
REQ-031 addr 1 holds 8'h22; wr_en=rd_en=1, addr 1, wdata 8'h5A -> rdata 8'h22; read addr 1 next cycle -> 8'h5A.
REQ-032 Read addr 0 (value 8'h11), then rd_en=0 for 3 cycles with addr changing -> rdata stays 8'h11.
REQ-033 wr_en=1 with reset=0, addr 3, wdata 8'h77 -> after reset, read addr 3 -> 8'hFF.
